conv_line_buffer_sequencer: RTL

- Sequences one frame of a feature-map stream into the 3x3 convolution line-buffer chain. The chain is two cascaded RAM-based shift registers plus window registers.
- Accepts pixels via a valid/ready handshake and generates the common shift enable and the programmed shift_size.
- Tracks row/column position and flags when the line buffers hold a complete, valid 3x3 window.
- Sits between the feature loader and the convolution PE array input stage.

---
 rtl/conv_line_buffer_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/conv_line_buffer_sequencer.sv
// Frame sequencer for the 3x3 convolution line-buffer chain: pixel handshake, shift enable, window tracking.
// Optional build macro CONV_STRIDE2_EN adds cfg_stride2, which keeps only even (row, col) windows.
//
// state | meaning
// IDLE  | waiting for cfg_start, no pixels accepted
// FILL  | rows 0 and 1 loading into the line buffers
// RUN   | rows 2..row_size-1, windows produced
// DONE  | one-cycle end-of-frame marker
module conv_line_buffer_sequencer #(
   parameter int COL_W    = 10,
   parameter int MIN_SIZE = 3
) (
   input  logic             system_clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic [COL_W-1:0] cfg_col_size,
   input  logic [COL_W-1:0] cfg_row_size,
`ifdef CONV_STRIDE2_EN
   input  logic             cfg_stride2,
`endif
   output logic             cfg_err,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             shift_en,
   output logic [9:0]       shift_size,
   output logic             window_valid,
   output logic [COL_W-1:0] window_row,
   output logic [COL_W-1:0] window_col
);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

   localparam logic [COL_W-1:0] ONE   = COL_W'(1);
   localparam logic [COL_W-1:0] TWO   = COL_W'(2);
   localparam logic [COL_W-1:0] MIN_V = COL_W'(MIN_SIZE);

   state_t           state_q;
   logic [COL_W-1:0] col_size_q;
   logic [COL_W-1:0] row_size_q;
   logic [COL_W-1:0] col_cnt_q;
   logic [COL_W-1:0] row_cnt_q;
   logic [9:0]       shift_size_q;
   logic             cfg_err_q;
   logic             busy_q;
   logic             done_q;
   logic             in_ready_q;
   logic             win_valid_q;
   logic [COL_W-1:0] win_row_q;
   logic [COL_W-1:0] win_col_q;
   logic [COL_W-1:0] shift_size_d;

   logic accept;
   logic cfg_ok;
   logic col_last;
   logic row_last;
   logic win_hit;

`ifdef CONV_STRIDE2_EN
   logic stride2_q;
   assign win_hit = (row_cnt_q >= TWO) && (col_cnt_q >= TWO) &&
                    (!stride2_q || (!row_cnt_q[0] && !col_cnt_q[0]));
`else
   assign win_hit = (row_cnt_q >= TWO) && (col_cnt_q >= TWO);
`endif

   assign accept       = in_valid & in_ready_q;
   assign cfg_ok       = (cfg_col_size >= MIN_V) && (cfg_row_size >= MIN_V);
   assign col_last     = (col_cnt_q == col_size_q - ONE);
   assign row_last     = (row_cnt_q == row_size_q - ONE);
   assign shift_size_d = cfg_col_size - TWO;

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_size_q   <= '0;
         row_size_q   <= '0;
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         shift_size_q <= '0;
         cfg_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         in_ready_q   <= 1'b0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
`ifdef CONV_STRIDE2_EN
         stride2_q    <= 1'b0;
`endif
      end else begin
         cfg_err_q   <= 1'b0;
         done_q      <= 1'b0;
         win_valid_q <= 1'b0;

         // Window flag lags the accept by one cycle to line up with the RAM read.
         if (accept) begin
            win_valid_q <= win_hit;
            if (win_hit) begin
               win_row_q <= row_cnt_q;
               win_col_q <= col_cnt_q;
            end
            if (col_last) begin
               col_cnt_q <= '0;
               row_cnt_q <= row_cnt_q + ONE;
            end else begin
               col_cnt_q <= col_cnt_q + ONE;
            end
         end

         case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  if (cfg_ok) begin
                     col_size_q   <= cfg_col_size;
                     row_size_q   <= cfg_row_size;
                     shift_size_q <= shift_size_d[9:0];
                     col_cnt_q    <= '0;
                     row_cnt_q    <= '0;
                     busy_q       <= 1'b1;
                     in_ready_q   <= 1'b1;
                     state_q      <= FILL;
`ifdef CONV_STRIDE2_EN
                     stride2_q    <= cfg_stride2;
`endif
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (accept && col_last && (row_cnt_q == ONE)) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (accept && col_last && row_last) begin
                  in_ready_q <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_err      = cfg_err_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign in_ready     = in_ready_q;
   assign shift_en     = accept;
   assign shift_size   = shift_size_q;
   assign window_valid = win_valid_q;
   assign window_row   = win_row_q;
   assign window_col   = win_col_q;

endmodule
